// File: rtl/arb_rr4_lanes_rx_pkg.sv
// rtl/arb_rr4_lanes_rx_pkg.sv - shared constants and output-state encoding for arb_rr4_lanes_rx
package arb_rr4_lanes_rx_pkg;

  localparam int NUM_LANES  = 4;
  localparam int LANE_W     = 2;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Lane index arithmetic wraps naturally at NUM_LANES because LANE_W is exact.
  function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] base,
                                                  input logic [LANE_W-1:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/arb_rr4_lanes_rx_lane_fifo_rx.sv
// rtl/arb_rr4_lanes_rx_lane_fifo_rx.sv - per-lane elastic FIFO with almost-full and sticky overflow
module lane_fifo_rx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_LEVEL   = 3,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              overflow
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic              wr_en;
  logic              rd_en;

  // A full FIFO still accepts a byte when its head leaves on the same edge.
  assign rd_en = pop && (count_q != '0);
  assign wr_en = push && ((count_q < CNT_W'(FIFO_DEPTH)) || rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    af_d  = (count_d >= CNT_W'(AF_LEVEL));
    ovf_d = ovf_q || (push && !wr_en);
  end

  // Storage needs no reset: emptiness is tracked by count and pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  assign dout        = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;

endmodule

// File: rtl/arb_rr4_lanes_rx.sv
// rtl/arb_rr4_lanes_rx.sv - round-robin merge of four rx lanes into one registered byte stream
// Optional per-lane transfer counters stat_cnt0..3 are built when ARB_LANE_STATS_EN is defined.
module arb_rr4_lanes_rx
  import arb_rr4_lanes_rx_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_LEVEL   = 3
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [3:0]        valid_in,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        lane_out,
  output logic [3:0]        almost_full,
  output logic [3:0]        overflow
`ifdef ARB_LANE_STATS_EN
  ,
  output logic [15:0]       stat_cnt0,
  output logic [15:0]       stat_cnt1,
  output logic [15:0]       stat_cnt2,
  output logic [15:0]       stat_cnt3
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] lane_din  [NUM_LANES];
  logic [DATA_W-1:0] lane_dout [NUM_LANES];
  logic [CNT_W-1:0]  lane_cnt  [NUM_LANES];
  logic [NUM_LANES-1:0] lane_nonempty;
  logic [NUM_LANES-1:0] pop_vec;

  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [LANE_W-1:0] last_grant_q, last_grant_d;

  logic              transfer;
  logic              load;
  logic              grant_found;
  logic [LANE_W-1:0] grant_lane;
  logic [LANE_W-1:0] cand;

  assign lane_din[0] = data_in0;
  assign lane_din[1] = data_in1;
  assign lane_din[2] = data_in2;
  assign lane_din[3] = data_in3;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fifo_rx #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .AF_LEVEL  (AF_LEVEL)
    ) u_fifo (
      .clk        (clk_4f),
      .rst        (reset),
      .push       (valid_in[i]),
      .pop        (pop_vec[i]),
      .din        (lane_din[i]),
      .dout       (lane_dout[i]),
      .count      (lane_cnt[i]),
      .almost_full(almost_full[i]),
      .overflow   (overflow[i])
    );
    assign lane_nonempty[i] = (lane_cnt[i] != '0);
  end

  // Search starts just after the last granted lane; offset NUM_LANES revisits it last.
  always_comb begin
    grant_found = 1'b0;
    grant_lane  = last_grant_q;
    cand        = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = next_lane(last_grant_q, LANE_W'(k));
      if (!grant_found && lane_nonempty[cand]) begin
        grant_found = 1'b1;
        grant_lane  = cand;
      end
    end
  end

  assign transfer = (state_q == ST_FULL) && ready_out;
  assign load     = (state_q == ST_EMPTY) || transfer;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    lane_d       = lane_q;
    last_grant_d = last_grant_q;
    pop_vec      = '0;
    if (load) begin
      if (grant_found) begin
        pop_vec[grant_lane] = 1'b1;
        data_d              = lane_dout[grant_lane];
        lane_d              = grant_lane;
        last_grant_d        = grant_lane;
        state_d             = ST_FULL;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      lane_q       <= '0;
      last_grant_q <= LANE_W'(NUM_LANES - 1);
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      lane_q       <= lane_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign valid_out = (state_q == ST_FULL);
  assign data_out  = data_q;
  assign lane_out  = lane_q;

`ifdef ARB_LANE_STATS_EN
  logic [15:0] stat_q [NUM_LANES];
  logic [15:0] stat_d [NUM_LANES];

  always_comb begin
    stat_d = stat_q;
    if (transfer) begin
      stat_d[lane_q] = stat_q[lane_q] + 16'd1;
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt0 = stat_q[0];
  assign stat_cnt1 = stat_q[1];
  assign stat_cnt2 = stat_q[2];
  assign stat_cnt3 = stat_q[3];
`endif

endmodule

// File: tb/tb_arb_rr4_lanes_rx.sv
// tb/tb_arb_rr4_lanes_rx.sv - scoreboard bench for arb_rr4_lanes_rx
module tb_arb_rr4_lanes_rx;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] valid_in = 4'b0;
  logic [7:0] data_in0 = 8'h00;
  logic [7:0] data_in1 = 8'h00;
  logic [7:0] data_in2 = 8'h00;
  logic [7:0] data_in3 = 8'h00;
  logic       ready_out = 1'b0;
  logic       valid_out;
  logic [7:0] data_out;
  logic [1:0] lane_out;
  logic [3:0] almost_full;
  logic [3:0] overflow;
`ifdef ARB_LANE_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  arb_rr4_lanes_rx dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .valid_in   (valid_in),
    .data_in0   (data_in0),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .data_in3   (data_in3),
    .ready_out  (ready_out),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .lane_out   (lane_out),
    .almost_full(almost_full),
    .overflow   (overflow)
`ifdef ARB_LANE_STATS_EN
    ,
    .stat_cnt0  (stat_cnt0),
    .stat_cnt1  (stat_cnt1),
    .stat_cnt2  (stat_cnt2),
    .stat_cnt3  (stat_cnt3)
`endif
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_complete", exp_q.size(), 0);
    chk("idle_after_drain", valid_out, 1'b0);
  endtask

  // Monitor: a byte is consumed at the next edge whenever valid_out && ready_out.
  always @(negedge clk_4f) begin
    if (!reset && valid_out && ready_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected actual=%0h lane=%0d required=none", data_out, lane_out);
      end else begin
        mon_e = exp_q.pop_front();
        if ({lane_out, data_out} !== mon_e) begin
          errors++;
          $display("FAIL out_byte actual=lane%0d:%0h required=lane%0d:%0h",
                   lane_out, data_out, mon_e[9:8], mon_e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] af_tab  [6];
    logic [3:0] ovf_tab [6];
    af_tab  = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2};
    ovf_tab = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};

    #2;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_lane_out", lane_out, 2'd0);
    chk("rst_almost_full", almost_full, 4'h0);
    chk("rst_overflow", overflow, 4'h0);
    step();
    reset = 1'b0;

    // Single byte on lane 0: no bypass, one cycle in FIFO then output.
    do_reset();
    ready_out = 1'b1;
    valid_in  = 4'b0001;
    data_in0  = 8'hA5;
    exp_q.push_back({2'd0, 8'hA5});
    step();
    valid_in = 4'b0000;
    chk("lat_no_bypass", valid_out, 1'b0);
    step();
    chk("lat_valid", valid_out, 1'b1);
    chk("lat_data", data_out, 8'hA5);
    chk("lat_lane", lane_out, 2'd0);
    step();
    chk("lat_done", valid_out, 1'b0);

    // Two rounds on all lanes: grant order 0,1,2,3,0,1,2,3.
    do_reset();
    ready_out = 1'b1;
    valid_in  = 4'b1111;
    {data_in0, data_in1, data_in2, data_in3} = {8'h10, 8'h20, 8'h30, 8'h40};
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h20});
    exp_q.push_back({2'd2, 8'h30});
    exp_q.push_back({2'd3, 8'h40});
    step();
    {data_in0, data_in1, data_in2, data_in3} = {8'h11, 8'h21, 8'h31, 8'h41};
    exp_q.push_back({2'd0, 8'h11});
    exp_q.push_back({2'd1, 8'h21});
    exp_q.push_back({2'd2, 8'h31});
    exp_q.push_back({2'd3, 8'h41});
    step();
    valid_in = 4'b0000;
    drain();

    // Backpressure hold on lane 2.
    do_reset();
    ready_out = 1'b0;
    valid_in  = 4'b0100;
    data_in2  = 8'h77;
    exp_q.push_back({2'd2, 8'h77});
    step();
    valid_in = 4'b0000;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", valid_out, 1'b1);
      chk("hold_data", data_out, 8'h77);
      chk("hold_lane", lane_out, 2'd2);
      step();
    end
    ready_out = 1'b1;
    step();
    chk("hold_popped_once", valid_out, 1'b0);
    chk("hold_sb_empty", exp_q.size(), 0);

    // Lane 1 filled with ready low: first byte goes to the output register,
    // FIFO fills at the fifth push, sixth push is dropped.
    do_reset();
    ready_out = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_in = 4'b0010;
      data_in1 = 8'h51 + 8'(i);
      if (i < 5) exp_q.push_back({2'd1, 8'h51 + 8'(i)});
      step();
      chk("fill_almost_full", almost_full, af_tab[i]);
      chk("fill_overflow", overflow, ovf_tab[i]);
    end
    valid_in  = 4'b0000;
    ready_out = 1'b1;
    drain();
    chk("fill_overflow_sticky", overflow, 4'h2);

    // Full FIFO with push and pop on the same edge: no drop.
    do_reset();
    ready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in = 4'b0010;
      data_in1 = 8'h61 + 8'(i);
      exp_q.push_back({2'd1, 8'h61 + 8'(i)});
      step();
    end
    chk("pp_full_af", almost_full, 4'h2);
    ready_out = 1'b1;
    data_in1  = 8'h66;
    exp_q.push_back({2'd1, 8'h66});
    step();
    valid_in = 4'b0000;
    chk("pp_no_overflow", overflow, 4'h0);
    chk("pp_af_kept", almost_full, 4'h2);
    drain();

    // Asynchronous reset in the middle of a burst.
    do_reset();
    ready_out = 1'b0;
    valid_in  = 4'b1111;
    {data_in0, data_in1, data_in2, data_in3} = {8'hE0, 8'hE1, 8'hE2, 8'hE3};
    for (int i = 0; i < 5; i++) step();
    valid_in = 4'b0000;
    chk("burst_af", almost_full, 4'hF);
    chk("burst_ovf", overflow, 4'hE);
    chk("burst_valid", valid_out, 1'b1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_valid_out", valid_out, 1'b0);
    chk("async_data_out", data_out, 8'h00);
    chk("async_af", almost_full, 4'h0);
    chk("async_ovf", overflow, 4'h0);
    @(negedge clk_4f);
    reset     = 1'b0;
    ready_out = 1'b1;
    valid_in  = 4'b1001;
    data_in0  = 8'hC0;
    data_in3  = 8'hC3;
    exp_q.push_back({2'd0, 8'hC0});
    exp_q.push_back({2'd3, 8'hC3});
    step();
    valid_in = 4'b0000;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
